ascon_ctrl_regs: RTL and testbench
==================================

Name: ascon_ctrl_regs

Overview:
- Hand-written, parametrised control/state register bank for the ASCON permutation core; replaces the fixed 5x64 generated-register wrapper.
- Adds a run FSM with busy tracking, sticky W1C done flag with interrupt, round-mode select, cycle counter, and bus write-lock of state while the core runs.
- Sits between the system register bus and the permutation datapath.

Parameters:
- DATA_W, 32, bus data width; LANE_W must be an integer multiple.
- LANES, 5, number of state lanes.
- LANE_W, 64, bits per lane.
- ADDR_W, 8, byte address width; the map below must fit.
- CNT_W, 32, cycle counter width (≤ DATA_W).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- reg_valid_i  in  1  bus request valid; held until reg_ready_o
- reg_write_i  in  1  1 = write, 0 = read
- reg_addr_i  in  ADDR_W  byte address, word aligned
- reg_wdata_i  in  DATA_W  write data
- reg_ready_o  out  1  one-cycle response strobe
- reg_rdata_o  out  DATA_W  read data, valid with reg_ready_o
- reg_error_o  out  1  error response, valid with reg_ready_o
- start_o  out  1  single-cycle start pulse to core
- rounds_o  out  2  round mode: 0=12, 1=8, 2=6, 3=reserved (treated as 12)
- busy_o  out  1  core running
- irq_o  out  1  done & irq_en, level
- finished_i  in  1  core completion pulse
- update_state_i  in  1  load state_i into state registers
- state_i  in  LANES*LANE_W  state from core, lane 0 in LSBs
- state_o  out  LANES*LANE_W  state to core, lane 0 in LSBs

Behaviour:
- Reset: all outputs 0; state, ctrl, done, irq_en and counter registers 0; FSM IDLE. Reset mid-run aborts with no start_o/irq_o glitch.
- Word map, offsets in units of DATA_W/8 bytes:
  - 0x0 CTRL: bit0 START, write-1 self-clearing, reads 0; bits[2:1] ROUNDS, R/W.
  - 0x1 STATUS: bit0 BUSY, RO; bit1 DONE, W1C.
  - 0x2 IRQ_EN: bit0, R/W.
  - 0x3 CYCLES: RO, zero-extended counter.
  - 0x4+i STATE word i, i < LANES*LANE_W/DATA_W; word i = lane i/(LANE_W/DATA_W), slice (i mod WPL)*DATA_W; low slice first.
- Bus: request sampled when reg_valid_i=1 and no response is pending. reg_ready_o asserts exactly the next cycle for one cycle, then ≥1 idle cycle before the next acceptance. Register side effects take place at the accept edge.
- Errors: set reg_error_o with rdata=0 and no side effect for:
  - unmapped or misaligned address;
  - write to a RO register;
  - STATE write while BUSY;
  - CTRL write with START=1 while BUSY (ROUNDS also unchanged).
- Reads of STATE during BUSY are allowed and return current contents.
- FSM IDLE:
  - accepted CTRL write with START=1 → BUSY; DONE cleared, counter cleared to 0.
  - start_o=1 in the cycle after accept (same cycle as reg_ready_o).
  - rounds_o reflects the new ROUNDS in that same cycle.
- FSM BUSY:
  - busy_o=1; counter +1 per cycle, saturating at all-ones.
  - finished_i=1 → IDLE next edge; DONE set; counter frozen.
  - finished_i is ignored in IDLE.
- update_state_i=1 loads state_i at the edge in any FSM state. It wins over a same-cycle bus STATE write, which is only possible in IDLE; that bus write is dropped but still acknowledged without error.
- DONE W1C written in the same cycle as finished_i: set wins.
- irq_o = DONE & IRQ_EN, registered; it falls the cycle after DONE is cleared or IRQ_EN is written to 0.
- state_o is driven straight from the state registers.

Decomposition:
- ascon_ctrl_pkg:
  - register offset localparams;
  - ctrl_t and status_t packed structs;
  - rounds_e enum;
  - fsm_e {IDLE, BUSY};
  - function word_to_lane(i) for the STATE address decode.
- Sub-module ascon_state_bank: parametrised LANES×LANE_W storage with DATA_W-granular bus write port, full-width hw load port with priority, and read mux. The top holds the decoder, FSM, counter and irq.

Test Plan:
- Reset, then read all 4 control words → 0, no error; state_o=0; irq_o=0.
- Write STATE words 0..9 with 0x1000_0000+i, read them back, check state_o lane 2 = 0x1000_0005_1000_0004; read 0x4+10 → error.
- Write CTRL=0x3 (START, ROUNDS=1) → start_o one cycle, rounds_o=1, busy_o=1; finished_i after 7 cycles → CYCLES reads 7, DONE=1; IRQ_EN=1 → irq_o=1; W1C STATUS=0x2 → irq_o 0 next cycle.
- While BUSY:
  - STATE write → error, contents unchanged;
  - START write → error, no second start_o;
  - STATE read → data, no error.
- update_state_i with state_i=0xA5 pattern, same cycle as a bus STATE write of 0xFFFF_FFFF in IDLE → register holds 0xA5 pattern, bus sees ack with no error.
- Assert rst_i mid-BUSY (counter=3) → all outputs 0 immediately; post-reset CYCLES=0, FSM IDLE, new START accepted.

Source files
------------

// File: rtl/ascon_ctrl_pkg.sv
// Shared definitions for the ASCON control/state register bank:
// word offsets, register field layouts, FSM states and the STATE word decode.
package ascon_ctrl_pkg;

  localparam int CTRL_OFF   = 0;
  localparam int STATUS_OFF = 1;
  localparam int IRQ_EN_OFF = 2;
  localparam int CYCLES_OFF = 3;
  localparam int STATE_OFF  = 4;

  typedef struct packed {
    logic [1:0] rounds;
    logic       start;
  } ctrl_t;

  typedef struct packed {
    logic done;
    logic busy;
  } status_t;

  typedef enum logic [1:0] {
    ROUNDS_12   = 2'd0,
    ROUNDS_8    = 2'd1,
    ROUNDS_6    = 2'd2,
    ROUNDS_RSVD = 2'd3
  } rounds_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } fsm_e;

  // STATE word i lives in lane i / words_per_lane, low slice first
  function automatic int word_to_lane(input int word, input int words_per_lane);
    return word / words_per_lane;
  endfunction

endpackage

// File: rtl/ascon_state_bank.sv
// LANES x LANE_W permutation state storage with a DATA_W-wide bus port,
// a full-width hardware load port that wins over the bus, and a word read mux.
module ascon_state_bank
  import ascon_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANES  = 5,
  parameter int LANE_W = 64,
  parameter int NWORDS = LANES * LANE_W / DATA_W,
  parameter int IDX_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bus_we,
  input  logic [IDX_W-1:0]          bus_idx,
  input  logic [DATA_W-1:0]         bus_wdata,
  input  logic                      hw_load,
  input  logic [LANES*LANE_W-1:0]   hw_state,
  output logic [DATA_W-1:0]         rd_data,
  output logic [LANES*LANE_W-1:0]   state
);

  localparam int WPL = LANE_W / DATA_W;

  for (genvar w = 0; w < NWORDS; w++) begin : g_word
    localparam int LANE  = word_to_lane(w, WPL);
    localparam int SLICE = w - LANE * WPL;
    localparam int BASE  = LANE * LANE_W + SLICE * DATA_W;

    logic [DATA_W-1:0] word_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        word_q <= '0;
      else if (hw_load)
        word_q <= hw_state[BASE +: DATA_W];
      else if (bus_we && bus_idx == IDX_W'(w))
        word_q <= bus_wdata;
    end

    assign state[BASE +: DATA_W] = word_q;
  end

  always_comb begin
    rd_data = '0;
    for (int w = 0; w < NWORDS; w++) begin
      if (bus_idx == IDX_W'(w))
        rd_data = state[word_to_lane(w, WPL) * LANE_W + (w % WPL) * DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/ascon_ctrl_regs.sv
// Control/status register bank for the ASCON permutation core: bus decoder,
// run FSM, cycle counter, sticky DONE with level interrupt, and state write-lock.
module ascon_ctrl_regs
  import ascon_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANES  = 5,
  parameter int LANE_W = 64,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     reg_valid_i,
  input  logic                     reg_write_i,
  input  logic [ADDR_W-1:0]        reg_addr_i,
  input  logic [DATA_W-1:0]        reg_wdata_i,
  output logic                     reg_ready_o,
  output logic [DATA_W-1:0]        reg_rdata_o,
  output logic                     reg_error_o,
  output logic                     start_o,
  output logic [1:0]               rounds_o,
  output logic                     busy_o,
  output logic                     irq_o,
  input  logic                     finished_i,
  input  logic                     update_state_i,
  input  logic [LANES*LANE_W-1:0]  state_i,
  output logic [LANES*LANE_W-1:0]  state_o
);

  localparam int BSH    = $clog2(DATA_W / 8);
  localparam int WA_W   = ADDR_W - BSH;
  localparam int NWORDS = LANES * LANE_W / DATA_W;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  fsm_e              fsm_q;
  rounds_e           rounds_q;
  logic              done_q;
  logic              irq_en_q;
  logic [CNT_W-1:0]  cycles_q;

  logic [WA_W-1:0]   word_addr;
  logic              misaligned;
  logic              accept;
  logic              busy;
  logic              is_ctrl, is_status, is_irqen, is_cycles, is_state;
  logic              bus_err;
  logic [IDX_W-1:0]  state_idx;
  logic [DATA_W-1:0] bank_rdata;
  logic [DATA_W-1:0] rd_mux;
  ctrl_t             wctrl;
  status_t           status_rd;
  logic              ctrl_wr, status_wr, irqen_wr, state_we;

  assign word_addr  = reg_addr_i[ADDR_W-1:BSH];
  assign misaligned = |reg_addr_i[BSH-1:0];
  // The response strobe doubles as the pending flag, forcing an idle cycle
  assign accept     = reg_valid_i & ~reg_ready_o;
  assign busy       = (fsm_q == BUSY);

  assign is_ctrl   = (word_addr == WA_W'(CTRL_OFF));
  assign is_status = (word_addr == WA_W'(STATUS_OFF));
  assign is_irqen  = (word_addr == WA_W'(IRQ_EN_OFF));
  assign is_cycles = (word_addr == WA_W'(CYCLES_OFF));
  assign is_state  = (word_addr >= WA_W'(STATE_OFF)) &&
                     (word_addr <  WA_W'(STATE_OFF + NWORDS));
  assign state_idx = IDX_W'(word_addr - WA_W'(STATE_OFF));
  assign wctrl     = ctrl_t'(reg_wdata_i[2:0]);

  assign bus_err = misaligned
                 | ~(is_ctrl | is_status | is_irqen | is_cycles | is_state)
                 | (reg_write_i & is_cycles)
                 | (reg_write_i & is_state & busy)
                 | (reg_write_i & is_ctrl & wctrl.start & busy);

  assign ctrl_wr   = accept & reg_write_i & ~bus_err & is_ctrl;
  assign status_wr = accept & reg_write_i & ~bus_err & is_status;
  assign irqen_wr  = accept & reg_write_i & ~bus_err & is_irqen;
  assign state_we  = accept & reg_write_i & ~bus_err & is_state;

  assign rounds_o  = rounds_q;
  assign status_rd = '{done: done_q, busy: busy};

  always_comb begin
    rd_mux = '0;
    if (is_ctrl)
      rd_mux = DATA_W'({rounds_o, 1'b0});
    else if (is_status)
      rd_mux = DATA_W'(status_rd);
    else if (is_irqen)
      rd_mux = DATA_W'(irq_en_q);
    else if (is_cycles)
      rd_mux = DATA_W'(cycles_q);
    else if (is_state)
      rd_mux = bank_rdata;
  end

  ascon_state_bank #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .LANE_W (LANE_W),
    .NWORDS (NWORDS),
    .IDX_W  (IDX_W)
  ) u_state_bank (
    .clk       (clk_i),
    .rst       (rst_i),
    .bus_we    (state_we),
    .bus_idx   (state_idx),
    .bus_wdata (reg_wdata_i),
    .hw_load   (update_state_i),
    .hw_state  (state_i),
    .rd_data   (bank_rdata),
    .state     (state_o)
  );

  // Run FSM plus every register it touches; a finish in the same cycle as a
  // DONE clear is assigned last so that the set wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fsm_q       <= IDLE;
      rounds_q    <= ROUNDS_12;
      done_q      <= 1'b0;
      irq_en_q    <= 1'b0;
      cycles_q    <= '0;
      start_o     <= 1'b0;
      busy_o      <= 1'b0;
      irq_o       <= 1'b0;
      reg_ready_o <= 1'b0;
      reg_error_o <= 1'b0;
      reg_rdata_o <= '0;
    end else begin
      start_o     <= 1'b0;
      irq_o       <= done_q & irq_en_q;
      reg_ready_o <= accept;
      reg_error_o <= accept & bus_err;
      reg_rdata_o <= (accept & ~bus_err & ~reg_write_i) ? rd_mux : '0;

      if (ctrl_wr)
        rounds_q <= rounds_e'(wctrl.rounds);
      if (irqen_wr)
        irq_en_q <= reg_wdata_i[0];
      if (status_wr && reg_wdata_i[1])
        done_q <= 1'b0;

      case (fsm_q)
        IDLE: begin
          if (ctrl_wr && wctrl.start) begin
            fsm_q    <= BUSY;
            start_o  <= 1'b1;
            busy_o   <= 1'b1;
            done_q   <= 1'b0;
            cycles_q <= '0;
          end
        end
        BUSY: begin
          if (finished_i) begin
            fsm_q  <= IDLE;
            busy_o <= 1'b0;
            done_q <= 1'b1;
          end else if (~&cycles_q) begin
            cycles_q <= cycles_q + CNT_W'(1);
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_ctrl_regs.sv
// Scoreboard bench for ascon_ctrl_regs: directed test-plan sequences followed by
// randomized bus/core traffic, all checked against a word-level reference model.
module tb_ascon_ctrl_regs;

  localparam int DATA_W = 32;
  localparam int LANES  = 5;
  localparam int LANE_W = 64;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 32;
  localparam int NW     = LANES * LANE_W / DATA_W;
  localparam int P      = 10;

  logic                    clk_i = 1'b0;
  logic                    rst_i = 1'b1;
  logic                    reg_valid_i = 1'b0;
  logic                    reg_write_i = 1'b0;
  logic [ADDR_W-1:0]       reg_addr_i = '0;
  logic [DATA_W-1:0]       reg_wdata_i = '0;
  logic                    reg_ready_o;
  logic [DATA_W-1:0]       reg_rdata_o;
  logic                    reg_error_o;
  logic                    start_o;
  logic [1:0]              rounds_o;
  logic                    busy_o;
  logic                    irq_o;
  logic                    finished_i = 1'b0;
  logic                    update_state_i = 1'b0;
  logic [LANES*LANE_W-1:0] state_i = '0;
  logic [LANES*LANE_W-1:0] state_o;

  ascon_ctrl_regs #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .LANE_W (LANE_W),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .reg_valid_i    (reg_valid_i),
    .reg_write_i    (reg_write_i),
    .reg_addr_i     (reg_addr_i),
    .reg_wdata_i    (reg_wdata_i),
    .reg_ready_o    (reg_ready_o),
    .reg_rdata_o    (reg_rdata_o),
    .reg_error_o    (reg_error_o),
    .start_o        (start_o),
    .rounds_o       (rounds_o),
    .busy_o         (busy_o),
    .irq_o          (irq_o),
    .finished_i     (finished_i),
    .update_state_i (update_state_i),
    .state_i        (state_i),
    .state_o        (state_o)
  );

  always #(P/2) clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q [$];

  // Reference model: register contents as plain words and flags
  logic [31:0] m_state [NW];
  logic [1:0]  m_rounds;
  bit          m_busy, m_done, m_irq_en;
  time         t_start;
  logic [31:0] m_cyc;
  int          m_starts = 0;
  int          starts_seen = 0;
  logic [LANES*LANE_W-1:0] upd_pat;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NW; i++) m_state[i] = '0;
    m_rounds = 2'd0; m_busy = 0; m_done = 0; m_irq_en = 0; m_cyc = '0;
  endtask

  // Counter equals the number of whole busy cycles since the start edge
  function automatic logic [31:0] cycVal(input time now);
    return m_busy ? 32'((now - t_start) / P - 1) : m_cyc;
  endfunction

  task automatic modelFinish(input time now);
    if (m_busy) begin
      m_cyc  = 32'((now - t_start) / P - 1);
      m_busy = 0;
      m_done = 1;
    end
  endtask

  task automatic modelAccept(input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                             input bit fin, input bit upd);
    int          word;
    bit          err;
    bit          was_busy;
    logic [31:0] rd;
    time         now;
    now      = $time;
    word     = int'(addr) / 4;
    was_busy = m_busy;
    rd       = '0;
    err = (addr % 4 != 0) || (word >= 4 + NW) || (wr && word == 3) ||
          (wr && word >= 4 && m_busy) || (wr && word == 0 && wd[0] && m_busy);
    if (!err && !wr) begin
      case (word)
        0:       rd = {29'd0, m_rounds, 1'b0};
        1:       rd = {30'd0, m_done, m_busy};
        2:       rd = {31'd0, m_irq_en};
        3:       rd = cycVal(now);
        default: rd = m_state[word - 4];
      endcase
    end
    if (!err && wr) begin
      case (word)
        0: begin
          m_rounds = wd[2:1];
          if (wd[0]) begin
            m_busy = 1; m_done = 0; t_start = now; m_starts++;
          end
        end
        1:       if (wd[1]) m_done = 0;
        2:       m_irq_en = wd[0];
        default: if (!upd) m_state[word - 4] = wd;
      endcase
    end
    if (fin && was_busy) modelFinish(now);
    if (upd) for (int i = 0; i < NW; i++) m_state[i] = upd_pat[i*32 +: 32];
    exp_q.push_back({err, rd});
  endtask

  // One bus transaction, started on a falling edge; optionally with a core
  // finish and/or state load landing on the same accept edge.
  task automatic applyStimulus(input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                               input bit fin, input bit upd);
    int n;
    reg_valid_i = 1'b1; reg_write_i = wr; reg_addr_i = addr; reg_wdata_i = wd;
    if (fin) finished_i = 1'b1;
    if (upd) begin state_i = upd_pat; update_state_i = 1'b1; end
    @(posedge clk_i);
    modelAccept(wr, addr, wd, fin, upd);
    @(negedge clk_i);
    finished_i = 1'b0; update_state_i = 1'b0;
    n = 0;
    while (!reg_ready_o && n < 8) begin @(negedge clk_i); n++; end
    if (!reg_ready_o) begin
      checks++; errors++;
      $display("[TB] FAIL ready_timeout actual=0 required=1 addr=%h", addr);
      void'(exp_q.pop_back());
    end
    reg_valid_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic pulseFinish();
    finished_i = 1'b1;
    @(posedge clk_i);
    modelFinish($time);
    @(negedge clk_i);
    finished_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic checkPins();
    checkOutput("busy_o", busy_o, m_busy);
    checkOutput("rounds_o", rounds_o, m_rounds);
    checkOutput("irq_o", irq_o, m_done & m_irq_en);
    checkOutput("start_count", starts_seen, m_starts);
    for (int l = 0; l < LANES; l++)
      checkOutput($sformatf("state_o_lane%0d", l), state_o[l*64 +: 64],
                  {m_state[2*l+1], m_state[2*l]});
  endtask

  // Monitor: every response strobe is matched against the oldest expectation
  always @(negedge clk_i) begin : monitor
    logic [32:0] e;
    if (reg_ready_o) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_ready actual=1 required=0");
      end else begin
        e = exp_q.pop_front();
        checkOutput("bus_response", {31'd0, reg_error_o, reg_rdata_o}, {31'd0, e});
      end
    end
    if (start_o) begin
      starts_seen++;
      checkOutput("start_with_ready", reg_ready_o, 1);
    end
  end

  initial begin
    modelReset();
    repeat (3) @(negedge clk_i);
    checkOutput("reset_outputs",
                {|state_o, reg_rdata_o, start_o, busy_o, irq_o, reg_ready_o, reg_error_o, rounds_o},
                '0);
    rst_i = 1'b0;
    @(negedge clk_i);

    for (int i = 0; i < 4; i++) applyStimulus(0, 8'(i*4), '0, 0, 0);
    checkPins();

    for (int i = 0; i < NW; i++) applyStimulus(1, 8'(16 + 4*i), 32'h1000_0000 + i, 0, 0);
    for (int i = 0; i < NW; i++) applyStimulus(0, 8'(16 + 4*i), '0, 0, 0);
    checkOutput("lane2_pattern", state_o[191:128], 64'h1000_0005_1000_0004);
    checkPins();
    applyStimulus(0, 8'(16 + 4*NW), '0, 0, 0);
    applyStimulus(0, 8'h05, '0, 0, 0);
    applyStimulus(1, 8'h0C, 32'h1234, 0, 0);
    applyStimulus(0, 8'hFC, '0, 0, 0);

    // First run: seven busy cycles before finish, then interrupt handshake
    applyStimulus(1, 8'h00, 32'h3, 0, 0);
    checkPins();
    repeat (6) @(negedge clk_i);
    pulseFinish();
    applyStimulus(0, 8'h0C, '0, 0, 0);
    applyStimulus(0, 8'h04, '0, 0, 0);
    applyStimulus(1, 8'h08, 32'h1, 0, 0);
    checkPins();
    applyStimulus(1, 8'h04, 32'h2, 0, 0);
    checkPins();

    // Second run: write lock and reads while busy
    applyStimulus(1, 8'h00, 32'h5, 0, 0);
    applyStimulus(1, 8'h10, 32'hDEAD_BEEF, 0, 0);
    applyStimulus(1, 8'h00, 32'h3, 0, 0);
    applyStimulus(0, 8'h20, '0, 0, 0);
    applyStimulus(0, 8'h0C, '0, 0, 0);
    applyStimulus(0, 8'h04, '0, 0, 0);
    checkPins();
    pulseFinish();
    checkPins();

    // Third run: DONE clear colliding with finish
    applyStimulus(1, 8'h00, 32'h1, 0, 0);
    applyStimulus(1, 8'h04, 32'h2, 1, 0);
    applyStimulus(0, 8'h04, '0, 0, 0);
    checkPins();

    for (int i = 0; i < NW; i++) upd_pat[i*32 +: 32] = 32'hA5A5_A5A5;
    applyStimulus(1, 8'h1C, 32'hFFFF_FFFF, 0, 1);
    applyStimulus(0, 8'h1C, '0, 0, 0);
    checkPins();

    // Reset in the middle of a run
    applyStimulus(1, 8'h00, 32'h1, 0, 0);
    repeat (2) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1 checkOutput("midrun_reset_outputs",
                   {|state_o, reg_rdata_o, start_o, busy_o, irq_o, reg_ready_o, reg_error_o, rounds_o},
                   '0);
    modelReset();
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    applyStimulus(0, 8'h0C, '0, 0, 0);
    applyStimulus(0, 8'h04, '0, 0, 0);
    applyStimulus(1, 8'h00, 32'h1, 0, 0);
    checkPins();
    repeat (3) @(negedge clk_i);
    pulseFinish();
    applyStimulus(0, 8'h0C, '0, 0, 0);

    // Randomized traffic
    for (int k = 0; k < 80; k++) begin
      logic [7:0] addr;
      bit wr, fin, upd;
      if ($urandom_range(0, 9) == 0) begin
        pulseFinish();
      end else begin
        if ($urandom_range(0, 3) != 0) addr = 8'(4 * $urandom_range(0, 14));
        else addr = 8'($urandom_range(0, 255));
        wr  = bit'($urandom_range(0, 1));
        fin = ($urandom_range(0, 7) == 0);
        upd = ($urandom_range(0, 7) == 0);
        for (int i = 0; i < NW; i++) upd_pat[i*32 +: 32] = $urandom;
        applyStimulus(wr, addr, $urandom, fin, upd);
      end
      checkPins();
    end

    repeat (2) @(negedge clk_i);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
